// File: rtl/ctrl_pkg.sv
// Shared opcode/function constants, final-step classes and sequencer state
// for the multicycle RISC controller.
package ctrl_pkg;

  typedef enum logic {RUN, HALT} ctrl_state_t;

  // Opcode field InsM = Ins[15:11]
  localparam logic [4:0] OP_ALU   = 5'b00000;  // ADD/ADC/SUB/SBB
  localparam logic [4:0] OP_LHI   = 5'b00001;
  localparam logic [4:0] OP_LLI   = 5'b00010;
  localparam logic [4:0] OP_LDRRI = 5'b00011;
  localparam logic [4:0] OP_LDRRR = 5'b00100;
  localparam logic [4:0] OP_STRRI = 5'b00101;
  localparam logic [4:0] OP_STRRR = 5'b00110;  // STRrr/CMP
  localparam logic [4:0] OP_ADDI  = 5'b00111;
  localparam logic [4:0] OP_SUBI  = 5'b01000;
  localparam logic [4:0] OP_MOV   = 5'b01011;
  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_JALRL = 5'b10001;
  localparam logic [4:0] OP_JALRR = 5'b10010;
  localparam logic [4:0] OP_JR    = 5'b10011;
  localparam logic [4:0] OP_BCC   = 5'b11000;  // BCC/BCS/BEQ/BNE
  localparam logic [4:0] OP_BAL   = 5'b11001;
  localparam logic [4:0] OP_SYS   = 5'b11100;  // OutR/HLT

  // Function field InsL = Ins[1:0]
  localparam logic [1:0] FN_STRRR = 2'b00;
  localparam logic [1:0] FN_CMP   = 2'b01;
  localparam logic [1:0] FN_OUTR  = 2'b00;
  localparam logic [1:0] FN_HLT   = 2'b01;

  localparam logic [2:0] STEP_BR  = 3'd2;
  localparam logic [2:0] STEP_ALU = 3'd3;
  localparam logic [2:0] STEP_LDR = 3'd4;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Connection bundle between the controller environment (master) and the
// step sequencer (slave).
interface ctrl_sequencer_if #(parameter int CNT_W = 3);
  import ctrl_pkg::*;

  // No valid/ready pair here: Stall=1 freezes the sequence for that cycle,
  // Run is a one-cycle pulse that only matters while Halted=1.
  logic [15:0]      Ins;
  logic             Stall;
  logic             Run;
  logic [CNT_W-1:0] Cnt;
  logic [4:0]       InsM;
  logic [1:0]       InsL;
  logic             LastStep;
  logic             Halted;
  logic             Illegal;
  ctrl_state_t      dbg_state;
  logic [15:0]      dbg_ir;

  modport master (
    output Ins, Stall, Run,
    input  Cnt, InsM, InsL, LastStep, Halted, Illegal, dbg_state, dbg_ir
  );

  modport slave (
    input  Ins, Stall, Run,
    output Cnt, InsM, InsL, LastStep, Halted, Illegal, dbg_state, dbg_ir
  );

endinterface

// File: rtl/ctrl_len_decode.sv
// Opcode table: maps InsM/InsL to the instruction's final step and flags
// HLT and undefined encodings.
module ctrl_len_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] ins_m,
  input  logic [1:0] ins_l,
  output logic [2:0] final_step,
  output logic       is_hlt,
  output logic       is_illegal
);

  always_comb begin
    final_step = STEP_BR;
    is_hlt     = 1'b0;
    is_illegal = 1'b0;
    case (ins_m)
      OP_BCC, OP_BAL, OP_JMP, OP_JR: final_step = STEP_BR;
      OP_SYS: begin
        is_hlt     = (ins_l == FN_HLT);
        is_illegal = !((ins_l == FN_OUTR) || (ins_l == FN_HLT));
      end
      OP_ALU, OP_LHI, OP_LLI, OP_STRRI, OP_ADDI, OP_SUBI, OP_MOV,
      OP_JALRL, OP_JALRR: final_step = STEP_ALU;
      OP_STRRR: begin
        if ((ins_l == FN_STRRR) || (ins_l == FN_CMP)) final_step = STEP_ALU;
        else                                           is_illegal = 1'b1;
      end
      OP_LDRRI, OP_LDRRR: final_step = STEP_LDR;
      // Undefined codes run as 2-step NOPs
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Step sequencer and instruction register: steps Cnt per instruction class,
// latches IR in step 1, handles HLT/Run and freezes on memory stall.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int          CNT_W  = 3,
  parameter logic [15:0] IR_RST = 16'h0000
) (
  input  logic            clk,
  input  logic            Rst,
  ctrl_sequencer_if.slave bus
);

  ctrl_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [15:0]      ir_q;
  logic             halted_q;
  logic             illegal_q;

  logic [4:0] ins_m;
  logic [1:0] ins_l;
  logic [2:0] final_step;
  logic       is_hlt;
  logic       is_illegal;
  logic       in_run;
  logic       load_step;
  logic       last_step;
  logic       illegal_next;

  // Step 1 decodes straight from the bus so decoders see the new opcode
  // in the same cycle it is being latched.
  assign load_step = (cnt_q == CNT_W'(1));
  assign ins_m     = load_step ? bus.Ins[15:11] : ir_q[15:11];
  assign ins_l     = load_step ? bus.Ins[1:0]   : ir_q[1:0];

  ctrl_len_decode u_len_decode (
    .ins_m      (ins_m),
    .ins_l      (ins_l),
    .final_step (final_step),
    .is_hlt     (is_hlt),
    .is_illegal (is_illegal)
  );

  assign in_run    = (state_q == RUN);
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_step = in_run && (cnt_q == CNT_W'(final_step));

  // Registered pulse: set only on the unstalled edge that enters the final
  // step, so a stall held on that step cannot re-trigger it.
  assign illegal_next = in_run && !bus.Stall && !last_step && is_illegal &&
                        (cnt_inc == CNT_W'(final_step));

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ir_q      <= IR_RST;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_next;
      case (state_q)
        RUN: begin
          if (!bus.Stall) begin
            if (load_step) ir_q <= bus.Ins;
            if (last_step) begin
              cnt_q <= '0;
              if (is_hlt) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        HALT: begin
          if (bus.Run) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) assert (cnt_q != '1);
  end

  assign bus.Cnt       = cnt_q;
  assign bus.InsM      = ins_m;
  assign bus.InsL      = ins_l;
  assign bus.LastStep  = last_step;
  assign bus.Halted    = halted_q;
  assign bus.Illegal   = illegal_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ir    = ir_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: step sequences, stall, HLT/Run,
// undefined opcodes, reset priority and a sweep of every defined instruction.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  logic clk;
  logic Rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  ctrl_sequencer_if #(.CNT_W(3)) bus ();

  ctrl_sequencer #(.CNT_W(3), .IR_RST(16'h0000)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "bench timeout");
  end

  // ---------------- expected instruction table ----------------
  localparam logic [15:0] SWEEP_INS [25] = '{
    16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'hC800, 16'h8000, 16'h9800,
    16'hE000, 16'hE001,
    16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0800, 16'h1000, 16'h2800,
    16'h3000, 16'h3001, 16'h3800, 16'h4000, 16'h5800, 16'h8800, 16'h9000,
    16'h1800, 16'h2000
  };
  localparam int SWEEP_FIN [25] = '{
    2, 2, 2, 2, 2, 2, 2, 2, 2,
    3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3,
    4, 4
  };

  // ---------------- driver / checker tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting in step 0; optionally stalls st_n cycles at step st_step.
  task automatic do_instr(input logic [15:0] ins, input int fin, input int st_step,
                          input int st_n, input logic ill);
    logic pulsed;
    int   reps;
    pulsed  = 1'b0;
    bus.Ins = ins;
    for (int s = 0; s <= fin; s++) begin
      reps = (s == st_step) ? st_n + 1 : 1;
      for (int k = 0; k < reps; k++) begin
        bus.Stall = (k < reps - 1);
        #1;
        check("cnt", 16'(bus.Cnt), 16'(s));
        check("last_step", 16'(bus.LastStep), 16'(s == fin));
        check("illegal", 16'(bus.Illegal), 16'(ill && (s == fin) && !pulsed));
        if (s >= 1) begin
          check("ins_m", 16'(bus.InsM), 16'(ins[15:11]));
          check("ins_l", 16'(bus.InsL), 16'(ins[1:0]));
        end
        if (s == fin) pulsed = 1'b1;
        cyc();
      end
    end
    bus.Stall = 1'b0;
    #1;
    check("wrap_cnt", 16'(bus.Cnt), 16'h0);
  endtask

  task automatic run_pulse();
    bus.Run = 1'b1;
    cyc();
    bus.Run = 1'b0;
    #1;
    check("run_halted", 16'(bus.Halted), 16'h0);
    check("run_cnt", 16'(bus.Cnt), 16'h0);
    check("run_state", 16'(bus.dbg_state), 16'(RUN));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Rst       = 1'b1;
    bus.Ins   = 16'h0000;
    bus.Stall = 1'b0;
    bus.Run   = 1'b0;
    cyc();
    cyc();

    // Reset state
    check("rst_cnt", 16'(bus.Cnt), 16'h0);
    check("rst_ins_m", 16'(bus.InsM), 16'h0);
    check("rst_ins_l", 16'(bus.InsL), 16'h0);
    check("rst_last", 16'(bus.LastStep), 16'h0);
    check("rst_halted", 16'(bus.Halted), 16'h0);
    check("rst_illegal", 16'(bus.Illegal), 16'h0);
    check("rst_ir", bus.dbg_ir, 16'h0000);
    Rst = 1'b0;

    // LHI: 0,1,2,3,0 with LastStep at 3
    do_instr(16'h0800, 3, -1, 0, 1'b0);
    check("lhi_ir", bus.dbg_ir, 16'h0800);

    // LDRrr with 2 stall cycles at step 2; Run held high in RUN is ignored
    bus.Run = 1'b1;
    do_instr(16'h2000, 4, 2, 2, 1'b0);
    bus.Run = 1'b0;

    // Stall on the final step of an ALU-class instruction
    do_instr(16'h3800, 3, 3, 3, 1'b0);

    // HLT: halt for 10 cycles, Stall in HALT ignored, then Run
    do_instr(16'hE001, 2, -1, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.Stall = (i % 3 == 0);
      #1;
      check("halt_halted", 16'(bus.Halted), 16'h1);
      check("halt_cnt", 16'(bus.Cnt), 16'h0);
      check("halt_last", 16'(bus.LastStep), 16'h0);
      check("halt_ir", bus.dbg_ir, 16'hE001);
      cyc();
    end
    bus.Stall = 1'b1;
    run_pulse();
    bus.Stall = 1'b0;
    do_instr(16'h1000, 3, -1, 0, 1'b0);

    // Undefined opcode: 3-cycle NOP with one Illegal pulse at step 2
    do_instr(16'hF800, 2, -1, 0, 1'b1);
    // Undefined SYS function, stalled on step 2: still a single pulse
    do_instr(16'hE002, 2, 2, 2, 1'b1);
    // Undefined STRrr-group function
    do_instr(16'h3003, 2, -1, 0, 1'b1);

    // Reset at step 3 of LDRri
    bus.Ins = 16'h1800;
    for (int s = 0; s <= 3; s++) begin
      #1;
      check("ldri_cnt", 16'(bus.Cnt), 16'(s));
      if (s < 3) cyc();
    end
    check("ldri_ins_m", 16'(bus.InsM), 16'(5'b00011));
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    #1;
    check("midrst_cnt", 16'(bus.Cnt), 16'h0);
    check("midrst_ir", bus.dbg_ir, 16'h0000);
    check("midrst_halted", 16'(bus.Halted), 16'h0);
    check("midrst_last", 16'(bus.LastStep), 16'h0);

    // Reset in HALT, together with Run: reset wins and IR is cleared
    do_instr(16'hE001, 2, -1, 0, 1'b0);
    check("pre_rst_halted", 16'(bus.Halted), 16'h1);
    bus.Run = 1'b1;
    Rst     = 1'b1;
    cyc();
    Rst     = 1'b0;
    bus.Run = 1'b0;
    #1;
    check("haltrst_cnt", 16'(bus.Cnt), 16'h0);
    check("haltrst_ir", bus.dbg_ir, 16'h0000);
    check("haltrst_halted", 16'(bus.Halted), 16'h0);
    check("haltrst_state", 16'(bus.dbg_state), 16'(RUN));

    // Sweep all 25 defined instructions back-to-back
    for (int i = 0; i < 25; i++) begin
      do_instr(SWEEP_INS[i], SWEEP_FIN[i], -1, 0, 1'b0);
      if (SWEEP_INS[i] == 16'hE001) begin
        check("sweep_hlt_halted", 16'(bus.Halted), 16'h1);
        run_pulse();
      end else begin
        check("sweep_halted", 16'(bus.Halted), 16'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Step sequencer and instruction register for the multicycle RISC controller. It generates the step count `Cnt` and latches the fetched instruction word. From these it drives the `InsM`/`InsL` fields consumed by the per-signal decoders (`Signal_LI`, `Signal_Buff_PC`, …). It also detects the last step of each instruction, handles `HLT` and resume, and freezes the sequence on memory stall.

## Interface
- `CNT_W`, default 3: width of step counter.
- `IR_RST`, default 16'h0000: instruction register reset value.
- `clk`  in  1  system clock, all state updates on rising edge.
- `Rst`  in  1  reset; synchronous and active-high.
- `Ins`  in  16  instruction word from memory data bus; sampled in step 1.
- `Stall`  in  1  memory not ready; freezes `Cnt` and IR.
- `Run`  in  1  one-cycle pulse; leaves HALT.
- `Cnt`  out  CNT_W  current step. Reset value 0.
- `InsM`  out  5  opcode field [15:11]. Reset value 0.
- `InsL`  out  2  function field [1:0]. Reset value 0.
- `LastStep`  out  1  current step is the final step of the instruction. Reset value 0.
- `Halted`  out  1  sequencer is in HALT. Reset value 0.
- `Illegal`  out  1  one-cycle pulse on the last step of an undefined opcode. Reset value 0.

## Operation
- States: RUN (stepping), HALT.
- In RUN, `Cnt` advances by 1 per cycle. It returns to 0 after a cycle with `LastStep`=1.
  - Step 0 fetches.
  - Step 1 loads IR from `Ins`.
- `InsM`/`InsL` source:
  - In step 1, combinational bypass of `Ins[15:11]`/`Ins[1:0]`.
  - Otherwise, from IR.
- Final step by opcode `InsM` (with `InsL` where noted):
  - Final step 2:
    - `BCC`/`BCS`/`BEQ`/`BNE` (11000), `BAL` (11001).
    - `JMP` (10000), `JR` (10011).
    - `OutR` (11100/00), `HLT` (11100/01).
    - Any undefined code.
  - Final step 3:
    - `ADD`/`ADC`/`SUB`/`SBB` (00000), `LHI` (00001), `LLI` (00010).
    - `STRri` (00101), `STRrr` (00110/00), `CMP` (00110/01).
    - `ADDI` (00111), `SUBI` (01000), `MOV` (01011).
    - `JALrl` (10001), `JALrr` (10010).
  - Final step 4: `LDRri` (00011), `LDRrr` (00100).
- `LastStep` is combinational: `Cnt` equals the final step of the current IR class and the state is RUN.
  - It is 0 in steps 0–1.
- Undefined opcodes execute as 2-step NOPs. `Illegal` pulses on their step 2.
- `HLT` in its last step: next state is HALT with `Cnt`=0 and `Halted`=1. IR is held.
- HALT exits when `Run`=1 → next cycle RUN, `Cnt`=0. `Run` in RUN is ignored.
- `Stall`=1 in RUN holds `Cnt`, IR and state unchanged. `LastStep` is then still asserted if the held step is final, and `Illegal` does not re-pulse. `Stall` in HALT is ignored.

## Timing
- `Rst` sampled high has priority over all inputs. Next cycle: RUN, `Cnt`=0, IR=`IR_RST`, all flags 0.
  - This applies mid-instruction and in HALT alike.
- Instruction latency is (final step + 1) cycles with no stall. Each stall cycle adds 1.
- IR captures `Ins` on the rising edge ending step 1, only if `Stall`=0.
- `Cnt` wrap: the counter never exceeds 4. Reaching 7 is an assertion failure.
- `Run` and `Rst` in the same cycle: `Rst` wins.
- `Halted` rises on the cycle after `HLT` step 2 and falls on the cycle after `Run`.

## Structure
- Shared package `ctrl_pkg` holds:
  - 5-bit opcode constants and 2-bit function constants.
  - Final-step constants `STEP_ALU`=3, `STEP_LDR`=4, `STEP_BR`=2.
  - State enum {RUN, HALT}.
- Sub-module `ctrl_len_decode`: combinational `InsM`,`InsL` → `final_step`, `is_hlt`, `is_illegal`. The opcode table lives in one place.
- Top holds the state register, counter, IR and bypass mux.

## Test plan
- Release `Rst`, `Ins`=16'h0800 (`LHI`), no stall → `Cnt` 0,1,2,3,0. `LastStep`=1 only at `Cnt`=3. `InsM`=5'b00001 from step 1.
- `LDRrr` (16'h2000), `Stall`=1 for 2 cycles at `Cnt`=2 → `Cnt` sequence 0,1,2,2,2,3,4,0, with `LastStep` at 4.
- `HLT` (16'hE001) → `Cnt` 0,1,2, then `Halted`=1 and `Cnt`=0 held for 10 cycles. `Run` pulse → `Halted`=0, next fetch at `Cnt`=0.
- Undefined opcode 16'hF800 → 3-cycle instruction, `Illegal`=1 exactly one cycle at `Cnt`=2.
- `Rst` asserted at `Cnt`=3 of `LDRri`, and separately in HALT → next cycle `Cnt`=0, IR=0, `Halted`=0.
- Sweep all 25 defined instructions back-to-back, checking each instruction's cycle count against the table.
